// File: rtl/hi_iq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hi_iq_pkg                                                         |
// | Brief  : Shared constants, FSM states and helpers for the SSP I/Q deframer.|
// |          Entry width depends on HI_IQ_DEFRAMER_AMPLITUDE_EN.               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package hi_iq_pkg;

  localparam int IQ_BYTE_W  = 8;
  localparam int FRAME_BITS = 16;

`ifdef HI_IQ_DEFRAMER_AMPLITUDE_EN
  localparam int ENTRY_W = 3 * IQ_BYTE_W;
`else
  localparam int ENTRY_W = 2 * IQ_BYTE_W;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef HI_IQ_DEFRAMER_AMPLITUDE_EN
  // Magnitude as unsigned 8-bit, so -128 maps to 128 without saturating.
  function automatic logic [IQ_BYTE_W-1:0] iq_abs(input logic [IQ_BYTE_W-1:0] v);
    logic [IQ_BYTE_W-1:0] r;
    r = v[IQ_BYTE_W-1] ? (~v + 1'b1) : v;
    return r;
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/hi_iq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hi_iq_fifo                                                        |
// | Brief  : First-word-fall-through FIFO; a push while full is accepted when  |
// |          a pop frees a slot in the same cycle.                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module hi_iq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_LVL_W-1:0] r_count;
  logic               w_pop;
  logic               w_push;

  assign o_full  = (r_count == c_LVL_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hi_iq_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hi_iq_deframer                                                    |
// | Brief  : Recovers signed I/Q byte pairs from the correlator SSP stream and |
// |          buffers them behind a valid/ready port.                           |
// |          Optional amplitude estimate: HI_IQ_DEFRAMER_AMPLITUDE_EN.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module hi_iq_deframer
  import hi_iq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          ck_1356meg,
  input  logic                          reset,
  input  logic                          ssp_clk,
  input  logic                          ssp_frame,
  input  logic                          ssp_din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_i,
  output logic [7:0]                    out_q,
  output logic [7:0]                    out_amp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [ERR_CNT_W-1:0]          frame_err_cnt
);

  localparam int c_CNT_W = $clog2(FRAME_BITS) + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_ssp_clk_q;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_CNT_W-1:0]      w_cnt_nxt;
  logic [FRAME_BITS-2:0]   r_shreg;
  logic [FRAME_BITS-2:0]   w_shreg_nxt;
  logic                    w_fall;
  logic                    w_push;
  logic                    w_frame_err;
  logic [FRAME_BITS-1:0]   w_word;
  logic [ENTRY_W-1:0]      w_entry;
  logic [ENTRY_W-1:0]      w_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_pop;
  logic                    r_overflow;
  logic [ERR_CNT_W-1:0]    r_err_cnt;

  // ssp_clk is launched on the opposite edge, so a plain register is enough.
  assign w_fall = r_ssp_clk_q & ~ssp_clk;
  assign w_word = {r_shreg, ssp_din};

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_ssp_clk_q <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
    end else begin
      r_ssp_clk_q <= ssp_clk;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall && ssp_frame) begin
          w_shreg_nxt = {{(FRAME_BITS-2){1'b0}}, ssp_din};
          w_cnt_nxt   = c_CNT_W'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_fall) begin
          if (ssp_frame) begin
            // Restart mid-word: drop the partial word, this bit is a new bit 15.
            w_frame_err = 1'b1;
            w_shreg_nxt = {{(FRAME_BITS-2){1'b0}}, ssp_din};
            w_cnt_nxt   = c_CNT_W'(1);
          end else if (r_cnt == c_CNT_W'(FRAME_BITS - 1)) begin
            w_push      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_shreg_nxt = {r_shreg[FRAME_BITS-3:0], ssp_din};
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HI_IQ_DEFRAMER_AMPLITUDE_EN
  logic [IQ_BYTE_W-1:0] w_abs_i;
  logic [IQ_BYTE_W-1:0] w_abs_q;
  logic [IQ_BYTE_W-1:0] w_amp;

  always_comb begin
    w_abs_i = iq_abs(w_word[FRAME_BITS-1:IQ_BYTE_W]);
    w_abs_q = iq_abs(w_word[IQ_BYTE_W-1:0]);
    if (w_abs_i >= w_abs_q) begin
      w_amp = w_abs_i + (w_abs_q >> 1);
    end else begin
      w_amp = w_abs_q + (w_abs_i >> 1);
    end
  end

  assign w_entry = {w_amp, w_word};
  assign out_amp = w_head[ENTRY_W-1:FRAME_BITS];
`else
  assign w_entry = w_word;
  assign out_amp = '0;
`endif

  assign out_valid = ~w_fifo_empty;
  assign w_pop     = out_valid & out_ready;
  assign out_i     = w_head[FRAME_BITS-1:IQ_BYTE_W];
  assign out_q     = w_head[IQ_BYTE_W-1:0];

  hi_iq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (ck_1356meg),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (w_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (fifo_level)
  );

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign overflow      = r_overflow;
  assign frame_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hi_iq_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hi_iq_deframer                                                 |
// | Brief  : Self-checking bench for hi_iq_deframer (SSP framing, FIFO rules,  |
// |          optional amplitude via HI_IQ_DEFRAMER_AMPLITUDE_EN).              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_hi_iq_deframer;

  localparam int FIFO_DEPTH = 4;
  localparam int ERR_CNT_W  = 8;
`ifdef HI_IQ_DEFRAMER_AMPLITUDE_EN
  localparam bit AMP_EN = 1'b1;
`else
  localparam bit AMP_EN = 1'b0;
`endif

  logic ck_1356meg = 1'b0;
  logic reset      = 1'b1;
  logic ssp_clk    = 1'b0;
  logic ssp_frame  = 1'b0;
  logic ssp_din    = 1'b0;
  logic out_ready  = 1'b0;
  logic                 out_valid;
  logic [7:0]           out_i;
  logic [7:0]           out_q;
  logic [7:0]           out_amp;
  logic [2:0]           fifo_level;
  logic                 overflow;
  logic [ERR_CNT_W-1:0] frame_err_cnt;

  always #5 ck_1356meg = ~ck_1356meg;

  hi_iq_deframer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .ck_1356meg    (ck_1356meg),
    .reset         (reset),
    .ssp_clk       (ssp_clk),
    .ssp_frame     (ssp_frame),
    .ssp_din       (ssp_din),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_i         (out_i),
    .out_q         (out_q),
    .out_amp       (out_amp),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .frame_err_cnt (frame_err_cnt)
  );

  int total = 0;
  int bad   = 0;
  int n_got = 0;
  int max_level = 0;

  // Reference model: words the consumer should see, in order.
  logic [15:0] exp_q[$];
  bit m_active;
  int m_nbits;
  int m_val;
  int m_err;
  bit m_ovf;

  typedef struct {
    logic [7:0] i;
    logic [7:0] q;
    int         exp_amp;
  } vec_t;

  function automatic int ref_amp(input logic [7:0] i, input logic [7:0] q);
    int ai, aq, hi, lo;
    ai = (int'(i) >= 128) ? 256 - int'(i) : int'(i);
    aq = (int'(q) >= 128) ? 256 - int'(q) : int'(q);
    hi = (ai > aq) ? ai : aq;
    lo = (ai > aq) ? aq : ai;
    return AMP_EN ? hi + lo / 2 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [15:0] w);
    if (exp_q.size() >= FIFO_DEPTH && !out_ready) m_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  task automatic model_bit(input logic fr, input logic d);
    if (fr) begin
      if (m_active) m_err = (m_err < (1 << ERR_CNT_W) - 1) ? m_err + 1 : m_err;
      m_active = 1'b1;
      m_nbits  = 1;
      m_val    = int'(d);
    end else if (m_active) begin
      m_val   = m_val * 2 + int'(d);
      m_nbits = m_nbits + 1;
      if (m_nbits == 16) begin
        model_push(16'(m_val));
        m_active = 1'b0;
        m_nbits  = 0;
      end
    end
  endtask

  // One SSP bit: 4 cycles, data launched on negedge, strobe on ssp_clk fall.
  task automatic send_bit(input logic fr, input logic d, input bit lat_chk, input bit rdy_pulse);
    @(negedge ck_1356meg);
    ssp_clk = 1'b1; ssp_frame = fr; ssp_din = d;
    @(negedge ck_1356meg);
    @(negedge ck_1356meg);
    ssp_clk = 1'b0;
    if (rdy_pulse) out_ready = 1'b1;
    model_bit(fr, d);
    if (lat_chk) begin
      #1 check("valid_before_push", int'(out_valid), 0);
    end
    @(negedge ck_1356meg);
    if (rdy_pulse) out_ready = 1'b0;
    if (lat_chk) begin
      #1 check("valid_after_push", int'(out_valid), 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] i, input logic [7:0] q, input bit lat_chk, input bit rdy_pulse);
    logic [15:0] w;
    w = {i, q};
    for (int k = 0; k < 16; k++) begin
      send_bit(k == 0, w[15-k], lat_chk && k == 15, rdy_pulse && k == 15);
    end
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      send_bit(k == 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge ck_1356meg);
    reset = 1'b1; ssp_clk = 1'b0; ssp_frame = 1'b0; ssp_din = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    m_active = 1'b0; m_nbits = 0; m_val = 0; m_err = 0; m_ovf = 1'b0;
    repeat (2) @(negedge ck_1356meg);
    reset = 1'b0;
  endtask

  task automatic drain();
    @(negedge ck_1356meg);
    out_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge ck_1356meg);
    check("drain_empty", exp_q.size(), 0);
    #1 check("drain_level", int'(fifo_level), 0);
  endtask

  // Consumer-side scoreboard: a word is taken when valid & ready ahead of a posedge.
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge ck_1356meg);
      #2;
      if (!reset) begin
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (out_valid && out_ready) begin
          n_got++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            w = exp_q.pop_front();
            check("word_i", int'(out_i), int'(w[15:8]));
            check("word_q", int'(out_q), int'(w[7:0]));
            check("word_amp", int'(out_amp), ref_amp(w[15:8], w[7:0]));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   base;
    vecs[0] = '{8'h5A, 8'hC3, AMP_EN ? 120 : 0};
    vecs[1] = '{8'h7F, 8'h80, AMP_EN ? 191 : 0};
    vecs[2] = '{8'h00, 8'h00, 0};
    vecs[3] = '{8'h80, 8'h80, AMP_EN ? 192 : 0};
    for (int v = 4; v < 6; v++) begin
      vecs[v].i = 8'($urandom_range(0, 255));
      vecs[v].q = 8'($urandom_range(0, 255));
      vecs[v].exp_amp = ref_amp(vecs[v].i, vecs[v].q);
    end

    do_reset();
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_i", int'(out_i), 0);
    check("rst_q", int'(out_q), 0);
    check("rst_amp", int'(out_amp), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_err", int'(frame_err_cnt), 0);

    // Single frames through an empty FIFO: latency and head contents.
    foreach (vecs[v]) begin
      send_frame(vecs[v].i, vecs[v].q, 1'b1, 1'b0);
      check("vec_i", int'(out_i), int'(vecs[v].i));
      check("vec_q", int'(out_q), int'(vecs[v].q));
      check("vec_amp", int'(out_amp), vecs[v].exp_amp);
      @(negedge ck_1356meg);
      out_ready = 1'b1;
      @(negedge ck_1356meg);
      out_ready = 1'b0;
      #1 check("vec_popped", int'(out_valid), 0);
    end

    // Back-to-back frames at the nominal cadence with the consumer always ready.
    @(negedge ck_1356meg);
    out_ready = 1'b1;
    max_level = 0;
    base = n_got;
    for (int f = 0; f < 10; f++) begin
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    drain();
    check("b2b_count", n_got - base, 10);
    check("b2b_err", int'(frame_err_cnt), 0);
    check("b2b_overflow", int'(overflow), 0);
    check("b2b_max_level_le1", int'(max_level <= 1), 1);

    // Consumer stalled: fifth word is dropped.
    @(negedge ck_1356meg);
    out_ready = 1'b0;
    base = n_got;
    for (int f = 0; f < 5; f++) begin
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    #1;
    check("ovf_level", int'(fifo_level), FIFO_DEPTH);
    check("ovf_flag", int'(overflow), int'(m_ovf));
    drain();
    check("ovf_count", n_got - base, 4);

    // Premature restart after 7 bits.
    do_reset();
    out_ready = 1'b1;
    base = n_got;
    send_partial(7);
    send_frame(8'h7F, 8'h80, 1'b0, 1'b0);
    drain();
    check("restart_err", int'(frame_err_cnt), m_err);
    check("restart_err_one", int'(frame_err_cnt), 1);
    check("restart_count", n_got - base, 1);

    // Reset in the middle of a frame.
    send_partial(9);
    do_reset();
    #1;
    check("midrst_err", int'(frame_err_cnt), 0);
    check("midrst_overflow", int'(overflow), 0);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_valid", int'(out_valid), 0);
    base = n_got;
    @(negedge ck_1356meg);
    out_ready = 1'b1;
    send_frame(8'h01, 8'h02, 1'b0, 1'b0);
    drain();
    check("midrst_count", n_got - base, 1);

    // Full FIFO with a push and a pop on the same edge.
    @(negedge ck_1356meg);
    out_ready = 1'b0;
    base = n_got;
    for (int f = 0; f < 4; f++) begin
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    #1 check("full_level", int'(fifo_level), FIFO_DEPTH);
    send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    check("pushpop_level", int'(fifo_level), FIFO_DEPTH);
    check("pushpop_overflow", int'(overflow), 0);
    drain();
    check("pushpop_count", n_got - base, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
